wave_shaper: RTL
================

Name: wave_shaper

Overview:
- Pipelined stage between the NCO phase/amplitude output and the Audio PWM stage.
- Maps the 8-bit NCO ramp to a selected waveform: saw, square, triangle or quarter-wave sine.
- Applies a click-free gain with a per-sample ramp and a mute fade.
- Presents an 8-bit unsigned, midscale-centred value that is held between samples for the PWM to consume continuously.

Parameters:
- WIDTH, 8, sample and phase width; only 8 is supported.
- GAIN_W, 4, gain width; gain_cur is in 0..15 and represents gain_cur/16.
- LUT_DEPTH, 64, quarter-wave sine table entries, indexed by phase[5:0].

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  asynchronous, active-low reset.
- phase_in  in  WIDTH  NCO output, used as phase.
- phase_valid  in  1  one-cycle sample strobe; may be high every cycle.
- wave_sel  in  2  waveform select: 00 saw, 01 square, 10 triangle, 11 sine.
- gain_target  in  GAIN_W  requested gain.
- mute  in  1  forces the effective target gain to 0.
- value_out  out  WIDTH  shaped sample, unsigned, 0x80 is silence.
- value_valid  out  1  one-cycle pulse when value_out updates.
- ramp_busy  out  1  high while gain_cur differs from the effective target.

Behaviour:
- Reset (async assert, sync release): value_out=0x80, value_valid=0, ramp_busy=0, gain_cur=0, all pipeline valid bits cleared, FSM=IDLE.
  - No valid pulse may emerge from pre-reset in-flight samples.
- S1 (capture): on phase_valid, register phase_in and wave_sel. A wave_sel change never affects samples already in flight.
- S2 (shape), result is an 8-bit value w:
  - saw: w=p.
  - square: w = p[7] ? 0xFF : 0x00.
  - triangle: w = p[7] ? ~{p[6:0],0} : {p[6:0],0}.
  - sine: q=LUT[p[6] ? ~p[5:0] : p[5:0]], where LUT[i]=round(127*sin(pi/2*(i+0.5)/64)) is 7-bit; w = p[7] ? 128-q : 128+q.
- S3 (gain):
  - x = w-128, 9-bit signed.
  - y = (x*gain_cur)>>>4, arithmetic shift, rounds toward -inf.
  - value_out = 128+y; output range is 8..247, no clamp needed.
- Latency: phase_valid at cycle N gives value_out updated and value_valid=1 at N+3. Full throughput, one sample per cycle. value_out holds between pulses.
- Gain FSM, with eff = mute ? 0 : gain_target:
  - IDLE: gain_cur==eff. When eff differs, go to RAMP.
  - RAMP: on each sample leaving S3, gain_cur moves by ±1 toward eff. S3 uses the pre-update gain_cur. When gain_cur==eff, go to IDLE, or to MUTED if mute=1.
  - MUTED: gain_cur==0 and mute=1. On mute deassert with gain_target≠0, go to RAMP.
  - Direction is re-evaluated at every step, so a target change mid-ramp reverses smoothly.
  - With no samples, gain_cur does not move.
- ramp_busy = (state==RAMP).
- Simultaneous mute and gain_target change: mute wins.

Decomposition:
- Package wave_pkg holds:
  - WAVE_SAW/SQR/TRI/SIN encodings.
  - MIDSCALE=8'h80.
  - LUT_DEPTH.
  - FSM state enum {IDLE, RAMP, MUTED}.
- Sub-module sine_quarter_lut: combinational 64x7 ROM, used in S2.

Test Plan:
- Reset: hold reset low, toggle phase_valid -> value_out=0x80, value_valid=0, ramp_busy=0. Release -> no stray value_valid.
- Saw, with gain ramped to 15 (15 prior strobes): phase 0x40 -> 3 cycles later value_valid=1, value_out=0x44 (68).
- Square, gain 15: phase 0x80 -> 0xF7 (247). Phase 0x7F -> 0x08.
- Ramp, saw, phase 0xFF, from gain_cur 0 with target 4:
  - Successive outputs 128,135,143,151, then 159 steady.
  - ramp_busy is high for exactly 4 samples.
- Back-to-back triangle, gain 15 settled: phases 0x00,0x40,0x80,0xC0 on consecutive cycles -> outputs 8,128,247,127 on consecutive cycles N+3..N+6.
- Mute from gain 15, saw phase 0xFF:
  - Outputs fall by one gain step per sample over 15 samples, then 0x80 steady with FSM=MUTED.
  - Deassert mute -> ramps back to 247.

Source files
------------

// File: rtl/wave_pkg.sv
// Shared encodings, constants and stage bundles for the wave shaper.
// Waveform select codes, midscale, LUT depth and gain FSM states.
package wave_pkg;

  localparam logic [1:0] WAVE_SAW = 2'b00;
  localparam logic [1:0] WAVE_SQR = 2'b01;
  localparam logic [1:0] WAVE_TRI = 2'b10;
  localparam logic [1:0] WAVE_SIN = 2'b11;

  localparam logic [7:0] MIDSCALE  = 8'h80;
  localparam int         LUT_DEPTH = 64;

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    MUTED
  } gain_state_t;

  typedef struct packed {
    logic [7:0] phase;
    logic [1:0] sel;
  } s1_t;

endpackage

// File: rtl/sine_quarter_lut.sv
// Quarter-wave sine ROM: round(127*sin(pi/2*(i+0.5)/64)).
// Combinational 64x7 table used by the shaping stage.
module sine_quarter_lut
  import wave_pkg::*;
(
  input  logic [5:0] idx,
  output logic [6:0] q
);

  localparam logic [6:0] ROM [LUT_DEPTH] = '{
    7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
    7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
    7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
    7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
    7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
    7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
    7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
  };

  assign q = ROM[idx];

endmodule

// File: rtl/wave_shaper.sv
// Three-stage NCO-to-PWM shaper: capture, waveform map, gain.
// Gain steps by one per emitted sample for click-free changes.
module wave_shaper
  import wave_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int GAIN_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  phase_in,
  input  logic              phase_valid,
  input  logic [1:0]        wave_sel,
  input  logic [GAIN_W-1:0] gain_target,
  input  logic              mute,
  output logic [WIDTH-1:0]  value_out,
  output logic              value_valid,
  output logic              ramp_busy
);

  localparam int PW = WIDTH + GAIN_W + 2;

  s1_t               s1;
  logic              s1_vld;
  logic              s2_vld;
  logic [WIDTH-1:0]  s2_w;
  logic [WIDTH-1:0]  p;
  logic [WIDTH-1:0]  w;
  logic [5:0]        lut_idx;
  logic [6:0]        lut_q;
  logic signed [WIDTH:0]  x;
  logic signed [GAIN_W:0] g_s;
  logic signed [PW-1:0]   prod;
  logic [WIDTH-1:0]  y;

  gain_state_t       state;
  gain_state_t       state_nxt;
  logic [GAIN_W-1:0] gain_cur;
  logic [GAIN_W-1:0] gain_nxt;
  logic [GAIN_W-1:0] eff;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld <= 1'b0;
      s1     <= '0;
    end else begin
      s1_vld <= phase_valid;
      if (phase_valid) begin
        s1.phase <= phase_in;
        s1.sel   <= wave_sel;
      end
    end
  end

  assign p       = s1.phase;
  assign lut_idx = p[6] ? ~p[5:0] : p[5:0];

  sine_quarter_lut u_lut (
    .idx (lut_idx),
    .q   (lut_q)
  );

  always_comb begin
    w = p;
    unique case (s1.sel)
      WAVE_SAW: w = p;
      WAVE_SQR: w = {WIDTH{p[7]}};
      WAVE_TRI: w = p[7] ? ~{p[6:0], 1'b0}
                         : {p[6:0], 1'b0};
      WAVE_SIN: w = p[7] ? MIDSCALE - {1'b0, lut_q}
                         : MIDSCALE + {1'b0, lut_q};
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_vld <= 1'b0;
      s2_w   <= MIDSCALE;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) s2_w <= w;
    end
  end

  // Arithmetic shift floors toward -inf; result always fits 8..247.
  always_comb begin
    x    = $signed({1'b0, s2_w} - {1'b0, MIDSCALE});
    g_s  = $signed({1'b0, gain_cur});
    prod = PW'(x) * PW'(g_s);
    y    = WIDTH'(prod >>> GAIN_W);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_out   <= MIDSCALE;
      value_valid <= 1'b0;
    end else begin
      value_valid <= s2_vld;
      if (s2_vld) value_out <= y + MIDSCALE;
    end
  end

  // Gain moves only when a sample leaves S3, using the old value there.
  always_comb begin
    eff       = mute ? '0 : gain_target;
    gain_nxt  = gain_cur;
    state_nxt = state;
    if (state == RAMP && s2_vld && gain_cur != eff)
      gain_nxt = (eff > gain_cur) ? gain_cur + 1'b1
                                  : gain_cur - 1'b1;
    unique case (state)
      IDLE: begin
        if (gain_cur != eff) state_nxt = RAMP;
        else if (mute)       state_nxt = MUTED;
      end
      RAMP: begin
        if (gain_nxt == eff)
          state_nxt = mute ? MUTED : IDLE;
      end
      MUTED: begin
        if (!mute)
          state_nxt = (gain_target != '0) ? RAMP : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      gain_cur <= '0;
    end else begin
      state    <= state_nxt;
      gain_cur <= gain_nxt;
    end
  end

  assign ramp_busy = (state == RAMP);

endmodule
